// File: rtl/ld_sequencer.sv
// Fetch/execute sequencer for LD r,d8 and LD rr,d16: owns the PC, reads bytes over a
// req/ack memory handshake with a bounded wait-state timeout, and strobes register writes.
`timescale 1ns/1ps
module ld_sequencer #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                MAX_WAIT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              rf_wr,
  output logic [3:0]        rf_sel,
  output logic [7:0]        rf_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal_op,
  output logic              bus_err
);

  localparam int              WAIT_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
  localparam logic            TIMEOUT_EN = (MAX_WAIT > 0);

  localparam logic [3:0] SEL_A   = 4'd0;
  localparam logic [3:0] SEL_B   = 4'd2;
  localparam logic [3:0] SEL_C   = 4'd3;
  localparam logic [3:0] SEL_D   = 4'd4;
  localparam logic [3:0] SEL_E   = 4'd5;
  localparam logic [3:0] SEL_H   = 4'd6;
  localparam logic [3:0] SEL_L   = 4'd7;
  localparam logic [3:0] SEL_SPH = 4'd8;
  localparam logic [3:0] SEL_SPL = 4'd9;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPER,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_NOP,
    K_LD8,
    K_LD16,
    K_HALT,
    K_ILL
  } kind_t;

  state_t            state;
  state_t            state_nxt;
  kind_t             dec_kind;
  logic [3:0]        dec_first;
  logic [3:0]        dec_second;
  logic [7:0]        opcode;
  logic [3:0]        sel_q;
  logic [3:0]        sel_next;
  logic [1:0]        bytes_left;
  logic [WAIT_W-1:0] wait_cnt;
  logic              req;
  logic              take;
  logic              timeout_hit;

  // Opcode classification; for 16-bit loads the low register is written first.
  always_comb begin
    dec_kind   = K_ILL;
    dec_first  = '0;
    dec_second = '0;
    case (opcode)
      8'h00: dec_kind = K_NOP;
      8'h76: dec_kind = K_HALT;
      8'h06: begin dec_kind = K_LD8;  dec_first = SEL_B; end
      8'h0E: begin dec_kind = K_LD8;  dec_first = SEL_C; end
      8'h16: begin dec_kind = K_LD8;  dec_first = SEL_D; end
      8'h1E: begin dec_kind = K_LD8;  dec_first = SEL_E; end
      8'h26: begin dec_kind = K_LD8;  dec_first = SEL_H; end
      8'h2E: begin dec_kind = K_LD8;  dec_first = SEL_L; end
      8'h3E: begin dec_kind = K_LD8;  dec_first = SEL_A; end
      8'h01: begin dec_kind = K_LD16; dec_first = SEL_C;   dec_second = SEL_B;   end
      8'h11: begin dec_kind = K_LD16; dec_first = SEL_E;   dec_second = SEL_D;   end
      8'h21: begin dec_kind = K_LD16; dec_first = SEL_L;   dec_second = SEL_H;   end
      8'h31: begin dec_kind = K_LD16; dec_first = SEL_SPL; dec_second = SEL_SPH; end
      default: ;
    endcase
  end

  // An ack arriving in the same cycle as the timeout takes priority over it.
  assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LIM);

  always_comb begin
    state_nxt  = state;
    req        = 1'b0;
    take       = 1'b0;
    rf_wr      = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    case (state)
      S_FETCH, S_OPER: begin
        req = 1'b1;
        if (mem_ack) begin
          take      = 1'b1;
          state_nxt = (state == S_FETCH) ? S_DECODE : S_WB;
        end else if (timeout_hit) begin
          bus_err   = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_DECODE: begin
        case (dec_kind)
          K_NOP:         state_nxt = S_FETCH;
          K_HALT:        state_nxt = S_HALT;
          K_LD8, K_LD16: state_nxt = S_OPER;
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_WB: begin
        rf_wr     = 1'b1;
        state_nxt = (bytes_left != 2'd0) ? S_OPER : S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // The request is masked while reset is held so every output reads zero (except pc).
  assign mem_rd   = req & ~rst;
  assign mem_addr = mem_rd ? pc : '0;
  assign halted   = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_VEC;
      wait_cnt   <= '0;
      bytes_left <= 2'd0;
      rf_sel     <= '0;
      rf_wdata   <= '0;
    end else begin
      state <= state_nxt;
      if (take)
        pc <= pc + ADDR_W'(1);
      if (take || !req)
        wait_cnt <= '0;
      else if (TIMEOUT_EN && !timeout_hit)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (state == S_DECODE)
        bytes_left <= (dec_kind == K_LD16) ? 2'd2 : (dec_kind == K_LD8) ? 2'd1 : 2'd0;
      else if (take && state == S_OPER)
        bytes_left <= bytes_left - 2'd1;
      // Write port values change only on the edge that raises rf_wr, so they hold otherwise.
      if (take && state == S_OPER) begin
        rf_sel   <= sel_q;
        rf_wdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take && state == S_FETCH)
      opcode <= mem_rdata;
    if (state == S_DECODE) begin
      sel_q    <= dec_first;
      sel_next <= dec_second;
    end else if (take && state == S_OPER) begin
      sel_q <= sel_next;
    end
  end

endmodule
